uart8_transmitter: RTL and testbench
====================================

UART8_TRANSMITTER -- requirements
Module: uart8_transmitter

Interface
REQ-001 SHALL have parameter CLOCK_RATE, default 100000000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, serial bit rate in bits/s.
REQ-003 SHALL derive CLKS_PER_BIT = CLOCK_RATE/BAUD_RATE (integer divide); values below 2 are illegal and SHALL fail elaboration.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge system clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 en  input  1  block enable; low forces idle.
REQ-007 start  input  1  request to send the byte on in; sampled on clk.
REQ-008 in  input  8  parallel data byte; captured when a request is accepted.
REQ-009 out  output  1  serial line, 8N1 framing, idle high.
REQ-010 busy  output  1  high while a frame is in progress.
REQ-011 done  output  1  one-cycle pulse when a frame completes.

Function
REQ-012 SHALL implement states IDLE, START, DATA, STOP; all outputs SHALL be registered.
REQ-013 In IDLE: out=1, busy=0; a request SHALL be accepted when en=1 and start=1 at a clk edge.
REQ-014 On acceptance: in SHALL be latched into an 8-bit shift register, bit index cleared, baud counter cleared, state->START; out=0 and busy=1 from the next cycle.
REQ-015 Each bit (start, 8 data, stop) SHALL be driven on out for exactly CLKS_PER_BIT cycles, timed by a baud counter that counts 0..CLKS_PER_BIT-1 and wraps.
REQ-016 START -> DATA on baud-counter wrap; DATA SHALL send bits LSB first, advancing the bit index on each wrap; after bit 7 wraps -> STOP.
REQ-017 STOP: out=1 for CLKS_PER_BIT cycles; on wrap -> IDLE with busy=0 and done=1 for exactly that one cycle.
REQ-018 Total frame length SHALL be 10*CLKS_PER_BIT cycles: from the cycle after acceptance through the last stop-bit cycle.
REQ-019 start asserted while busy=1 SHALL be ignored, with no queuing; changes on in while busy SHALL not affect the frame in progress.
REQ-020 start=1 in the cycle done=1 SHALL be accepted, so back-to-back frames are separated by exactly one idle-high cycle.
REQ-021 en=0 at any clk edge SHALL abort the frame: next cycle state=IDLE, out=1, busy=0, done=0, counters cleared; no done pulse is produced for the aborted frame.
REQ-022 done SHALL never be asserted together with busy=1.

Reset
REQ-023 rst=1 SHALL asynchronously force state=IDLE, out=1, busy=0, done=0, and clear the shift register, bit index and baud counter, including mid-frame.
REQ-024 After rst deasserts, the first request SHALL be accepted at the first clk edge with en=1 and start=1.

Structure
REQ-025 Shared package uart8_pkg SHALL hold the state enumeration, DEFAULT_CLOCK_RATE, DEFAULT_BAUD_RATE and the frame constants DATA_BITS=8 and STOP_BITS=1.
REQ-026 The baud counter SHALL be one sub-module, uart8_baud_tick, with inputs clk, rst, clear, and output tick (wrap pulse); the FSM and shift register reside in uart8_transmitter.

Verification (CLOCK_RATE=16, BAUD_RATE=1, so CLKS_PER_BIT=16; acceptance edge = T)
REQ-027 Send 0xA5 -> out = 0,1,0,1,0,0,1,0,1,1, each for 16 cycles, over T+1..T+160; busy=1 over T+1..T+160; done=1 only at T+161.
REQ-028 start with in=0x3C at T+40 during the 0xA5 frame -> frame unchanged, no second frame, single done pulse.
REQ-029 start held high with in=0x00 then 0xFF -> second start bit begins at T+162, exactly one idle-high cycle (T+161) between frames; two done pulses.
REQ-030 en=0 during data bit 3 of 0x0F -> next cycle out=1, busy=0, no done pulse; a new request then sends a full frame.
REQ-031 rst pulse at T+70 of a 0x55 frame -> out=1, busy=0, done=0 immediately, before the next clk edge; after release, 0x55 is re-sent correctly.
REQ-032 Random bytes, 200 frames, checked by a reference 8N1 sampler at bit centres -> all bytes match, frame length is always 160 cycles.

Source files
------------

// File: rtl/uart8_pkg.sv
// Shared constants and state encodings for the 8N1 UART transmitter.
package uart8_pkg;

   localparam int unsigned DEFAULT_CLOCK_RATE = 100000000;
   localparam int unsigned DEFAULT_BAUD_RATE  = 9600;
   localparam int unsigned DATA_BITS          = 8;
   localparam int unsigned STOP_BITS          = 1;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_START = 2'd1;
   localparam state_t ST_DATA  = 2'd2;
   localparam state_t ST_STOP  = 2'd3;

endpackage

// File: rtl/uart8_baud_tick.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 and flags the last count as a wrap tick.
module uart8_baud_tick #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

   logic [CW-1:0] count;

   always_comb tick = (count == CW'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear || tick) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/uart8_transmitter.sv
// 8N1 serial transmitter: FSM and shift register, bit timing from uart8_baud_tick.
module uart8_transmitter
   import uart8_pkg::*;
#(
   parameter int unsigned CLOCK_RATE = DEFAULT_CLOCK_RATE,
   parameter int unsigned BAUD_RATE  = DEFAULT_BAUD_RATE
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       start,
   input  logic [7:0] in,
   output logic       out,
   output logic       busy,
   output logic       done
);

   localparam int unsigned CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;

   generate
      if (CLKS_PER_BIT < 2) begin : g_bad_rate
         $error("uart8_transmitter: CLOCK_RATE/BAUD_RATE must be at least 2");
      end
   endgenerate

   state_t     state;
   logic [7:0] shreg;
   logic [2:0] idx;
   logic       clear;
   logic       tick;

   // Counter held at zero while idle or disabled, so every bit starts at count 0.
   always_comb clear = (state == ST_IDLE) || !en;

   uart8_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk  (clk),
      .rst  (rst),
      .clear(clear),
      .tick (tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         out   <= 1'b1;
         busy  <= 1'b0;
         done  <= 1'b0;
         shreg <= '0;
         idx   <= '0;
      end else begin
         done <= 1'b0;
         if (!en) begin
            state <= ST_IDLE;
            out   <= 1'b1;
            busy  <= 1'b0;
            shreg <= '0;
            idx   <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start) begin
                     shreg <= in;
                     idx   <= '0;
                     state <= ST_START;
                     out   <= 1'b0;
                     busy  <= 1'b1;
                  end
               end
               ST_START: begin
                  if (tick) begin
                     out   <= shreg[0];
                     shreg <= {1'b0, shreg[7:1]};
                     state <= ST_DATA;
                  end
               end
               ST_DATA: begin
                  if (tick) begin
                     if (idx == 3'(DATA_BITS - 1)) begin
                        state <= ST_STOP;
                        out   <= 1'b1;
                     end else begin
                        out   <= shreg[0];
                        shreg <= {1'b0, shreg[7:1]};
                        idx   <= idx + 3'd1;
                     end
                  end
               end
               ST_STOP: begin
                  if (tick) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart8_transmitter.sv
// Self-checking bench for uart8_transmitter at 16 clocks per bit.
module tb_uart8_transmitter;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       start;
   logic [7:0] in;
   logic       out;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;   // bit 0 is transmitted first (start bit)
   } vec_t;

   vec_t vecs [6];

   uart8_transmitter #(
      .CLOCK_RATE(16),
      .BAUD_RATE (1)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .start(start),
      .in   (in),
      .out  (out),
      .busy (busy),
      .done (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Runs one frame; outputs sampled at negedge, k = cycles after the acceptance edge.
   task automatic run_frame(input logic [7:0] d, input logic [9:0] exp, input bit pre_started,
                            input bit keep_start, input logic [7:0] next_d, input int inj_k,
                            input string tag);
      if (!pre_started) begin
         @(negedge clk);
         in    = d;
         start = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      if (!keep_start) start = 1'b0;
      for (int k = 0; k < 160; k++) begin
         if (k == inj_k) begin
            in    = 8'h3C;
            start = 1'b1;
         end else if (inj_k >= 0 && k == inj_k + 1) begin
            start = 1'b0;
         end
         check($sformatf("%s out k=%0d", tag, k), 32'(out), 32'(exp[k/16]));
         check($sformatf("%s busy k=%0d", tag, k), 32'(busy), 32'd1);
         check($sformatf("%s done k=%0d", tag, k), 32'(done), 32'd0);
         @(negedge clk);
      end
      check($sformatf("%s done pulse", tag), 32'(done), 32'd1);
      check($sformatf("%s busy at done", tag), 32'(busy), 32'd0);
      check($sformatf("%s idle out at done", tag), 32'(out), 32'd1);
      if (keep_start) in = next_d;
   endtask

   task automatic idle_check(input int cycles, input string tag);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         check($sformatf("%s busy", tag), 32'(busy), 32'd0);
         check($sformatf("%s done", tag), 32'(done), 32'd0);
         check($sformatf("%s out", tag), 32'(out), 32'd1);
      end
   endtask

   initial begin
      logic [7:0] d;
      logic [9:0] bits;
      int         len;
      bit         seen;

      vecs[0] = '{8'hA5, 10'b1101001010};
      vecs[1] = '{8'h00, 10'b1000000000};
      vecs[2] = '{8'hFF, 10'b1111111110};
      vecs[3] = '{8'h3C, 10'b1001111000};
      vecs[4] = '{8'h80, 10'b1100000000};
      vecs[5] = '{8'h01, 10'b1000000010};

      rst   = 1'b1;
      en    = 1'b1;
      start = 1'b0;
      in    = 8'h00;
      #1;
      check("reset out", 32'(out), 32'd1);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      idle_check(3, "idle after reset");

      foreach (vecs[i])
         run_frame(vecs[i].data, vecs[i].frame, 1'b0, 1'b0, 8'h00, -1, $sformatf("vec%0d", i));

      // Request during a frame is ignored and in changes do not leak into it.
      run_frame(8'hA5, 10'b1101001010, 1'b0, 1'b0, 8'h00, 39, "ignore");
      idle_check(200, "no second frame");

      // Start held high: second frame starts right after the done cycle.
      run_frame(8'h00, 10'b1000000000, 1'b0, 1'b1, 8'hFF, -1, "b2b first");
      run_frame(8'hFF, 10'b1111111110, 1'b1, 1'b0, 8'h00, -1, "b2b second");
      idle_check(2, "after b2b");

      // Abort with en low during data bit 3.
      @(negedge clk);
      in    = 8'h0F;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 70; k++) @(negedge clk);
      check("pre-abort busy", 32'(busy), 32'd1);
      en = 1'b0;
      @(negedge clk);
      check("abort out", 32'(out), 32'd1);
      check("abort busy", 32'(busy), 32'd0);
      check("abort done", 32'(done), 32'd0);
      en = 1'b1;
      idle_check(200, "after abort");
      run_frame(8'h0F, 10'b1000011110, 1'b0, 1'b0, 8'h00, -1, "post-abort");

      // Asynchronous reset mid-frame.
      @(negedge clk);
      in    = 8'h55;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 69; k++) @(negedge clk);
      check("pre-reset out", 32'(out), 32'd0);
      check("pre-reset busy", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("async reset out", 32'(out), 32'd1);
      check("async reset busy", 32'(busy), 32'd0);
      check("async reset done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      idle_check(2, "after mid reset");
      run_frame(8'h55, 10'b1010101010, 1'b0, 1'b0, 8'h00, -1, "resend 55");

      // Random frames checked by a bit-centre sampler.
      for (int f = 0; f < 200; f++) begin
         d = 8'($urandom_range(0, 255));
         @(negedge clk);
         in    = d;
         start = 1'b1;
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         in    = 8'($urandom_range(0, 255));
         bits  = '0;
         len   = 0;
         seen  = 1'b0;
         for (int k = 0; k < 400 && !seen; k++) begin
            if (done) begin
               seen = 1'b1;
            end else begin
               if (busy) len++;
               if (k < 160 && (k % 16) == 8) bits[k/16] = out;
               @(negedge clk);
            end
         end
         check($sformatf("rand%0d done seen", f), 32'(seen), 32'd1);
         check($sformatf("rand%0d length", f), 32'(len), 32'd160);
         check($sformatf("rand%0d start bit", f), 32'(bits[0]), 32'd0);
         check($sformatf("rand%0d stop bit", f), 32'(bits[9]), 32'd1);
         check($sformatf("rand%0d data", f), 32'(bits[8:1]), 32'(d));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
